// File: rtl/ysyx_22040759_mul_ctrl.sv
// ysyx_22040759_mul_ctrl
//   Sequencer between the EXU and the booth-2 multiplier for the RV64M
//   multiply group (MUL, MULH, MULHSU, MULHU, MULW). It accepts one request
//   at a time and drives the multiplier's valid/ready/flush handshake. It then
//   formats the result and holds it for writeback until accepted.
//   Requests with a zero operand, and reserved opcodes, skip the multiplier
//   and complete with a zero result.
//
// Ports
//   clock, reset      single clock; synchronous active-high reset
//   ex_mul_req/op     EXU request, held until ex_mul_ack; op 0..4, 5-7 reserved
//   ex_src1/ex_src2   multiplicand / multiplier
//   ex_rd             destination register
//   flush             cancels whatever operation is in progress
//   ex_mul_ack        one-cycle pulse when writeback takes the result
//   wb_valid/ready    result handshake towards writeback
//   wb_rd/wb_data     latched rd and formatted result
//   m_*               command/operand outputs and result inputs of the multiplier
module ysyx_22040759_mul_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_mul_req,
  input  logic [2:0]      ex_mul_op,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [XLEN-1:0] ex_src2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            ex_mul_ack,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            m_valid,
  output logic            m_flush,
  output logic            m_mulw,
  output logic [1:0]      m_signed,
  output logic [XLEN-1:0] m_multiplicand,
  output logic [XLEN-1:0] m_multiplier,
  input  logic            m_ready,
  input  logic            m_out_valid,
  input  logic [XLEN-1:0] m_hi,
  input  logic [XLEN-1:0] m_lo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [1:0]      signed_q, signed_d;
  logic            mulw_q, mulw_d;

  logic            bypass;
  logic [XLEN-1:0] formatted;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      rd_q     <= '0;
      result_q <= '0;
      signed_q <= '0;
      mulw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      signed_q <= signed_d;
      mulw_q   <= mulw_d;
    end
  end

  // A product is trivially zero when an operand is zero; MULW only looks at
  // the low words, so a zero low word is enough there. Reserved ops also
  // complete with zero without touching the multiplier.
  always_comb begin
    bypass = 1'b0;
    if (ex_mul_op > OP_MULW) begin
      bypass = 1'b1;
    end else if (ex_mul_op == OP_MULW) begin
      bypass = (ex_src1[31:0] == 32'd0) || (ex_src2[31:0] == 32'd0);
    end else begin
      bypass = (ex_src1 == '0) || (ex_src2 == '0);
    end
  end

  always_comb begin
    formatted = '0;
    case (op_q)
      OP_MUL:                       formatted = m_lo;
      OP_MULH, OP_MULHSU, OP_MULHU: formatted = m_hi;
      OP_MULW:                      formatted = {{(XLEN-32){m_lo[31]}}, m_lo[31:0]};
      default:                      formatted = '0;
    endcase
  end

  // Flush is tested first in every state so it wins over ready/out_valid/wb_ready.
  // The handshake pulses are masked during reset so that a reset in the middle
  // of an operation neither flushes the multiplier nor acknowledges the EXU.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    rd_d       = rd_q;
    result_d   = result_q;
    signed_d   = signed_q;
    mulw_d     = mulw_q;
    m_valid    = 1'b0;
    m_flush    = 1'b0;
    ex_mul_ack = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_mul_req && !flush) begin
          op_d   = ex_mul_op;
          src1_d = ex_src1;
          src2_d = ex_src2;
          rd_d   = ex_rd;
          mulw_d = (ex_mul_op == OP_MULW);
          case (ex_mul_op)
            OP_MUL, OP_MULH, OP_MULW: signed_d = 2'b11;
            OP_MULHSU:                signed_d = 2'b10;
            default:                  signed_d = 2'b00;
          endcase
          if (bypass) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (flush) begin
          m_flush = 1'b1;
          state_d = S_IDLE;
        end else begin
          m_valid = 1'b1;
          if (m_ready) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          m_flush = 1'b1;
          state_d = S_IDLE;
        end else if (m_out_valid) begin
          result_d = formatted;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (wb_ready) begin
          ex_mul_ack = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      m_valid    = 1'b0;
      m_flush    = 1'b0;
      ex_mul_ack = 1'b0;
    end
  end

  assign wb_valid       = (state_q == S_DONE);
  assign wb_rd          = rd_q;
  assign wb_data        = result_q;
  assign m_mulw         = mulw_q;
  assign m_signed       = signed_q;
  assign m_multiplicand = src1_q;
  assign m_multiplier   = src2_q;

endmodule

// File: tb/tb_ysyx_22040759_mul_ctrl.sv
// tb_ysyx_22040759_mul_ctrl
//   Self-checking bench for the multiply sequencer. A behavioural multiplier
//   answers the handshake with a random latency, and the expected writeback
//   value comes from plain 128-bit arithmetic on the original operands.
module tb_ysyx_22040759_mul_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_mul_req;
  logic [2:0]  ex_mul_op;
  logic [63:0] ex_src1, ex_src2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        ex_mul_ack;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        m_valid, m_flush, m_mulw;
  logic [1:0]  m_signed;
  logic [63:0] m_multiplicand, m_multiplier;
  logic        m_ready, m_out_valid;
  logic [63:0] m_hi, m_lo;

  ysyx_22040759_mul_ctrl #(.XLEN(64)) dut (
    .clock(clock), .reset(reset),
    .ex_mul_req(ex_mul_req), .ex_mul_op(ex_mul_op),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_rd(ex_rd),
    .flush(flush), .ex_mul_ack(ex_mul_ack),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .m_valid(m_valid), .m_flush(m_flush), .m_mulw(m_mulw), .m_signed(m_signed),
    .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
    .m_ready(m_ready), .m_out_valid(m_out_valid), .m_hi(m_hi), .m_lo(m_lo)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Expectations for the operation currently presented by the EXU.
  logic [63:0] exp_data = '0;
  logic [4:0]  exp_rd = '0;
  logic        exp_bypass = 1'b0;
  logic [1:0]  exp_signed = '0;
  logic        exp_mulw = 1'b0;
  logic [63:0] exp_a = '0, exp_b = '0;

  // Controls of the behavioural multiplier, written only by the main process.
  logic hold_long = 1'b0;
  int   late_req  = 0;

  // Behavioural multiplier state, written only by its own process.
  logic        fm_busy;
  int          fm_cnt;
  int          late_done;
  logic [63:0] fm_hi, fm_lo;

  // ---------------- reference rules ----------------
  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  w;
    case (op)
      3'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic is_bypass(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op > 3'd4) return 1'b1;
    if (op == 3'd4) return (a[31:0] == 32'd0) || (b[31:0] == 32'd0);
    return (a == 64'd0) || (b == 64'd0);
  endfunction

  function automatic logic [1:0] sig_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd4: return 2'b11;
      3'd2:             return 2'b10;
      default:          return 2'b00;
    endcase
  endfunction

  function automatic logic [63:0] rand_operand();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: return 64'd0;
      1: return {$urandom, 32'd0};
      2: return 64'($urandom_range(1, 100));
      3: return {64{1'b1}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- behavioural multiplier ----------------
  initial begin
    logic [127:0] ea, eb, p;
    m_ready = 1'b0; m_out_valid = 1'b0; m_hi = '0; m_lo = '0;
    fm_busy = 1'b0; fm_cnt = 0; late_done = 0; fm_hi = '0; fm_lo = '0;
    forever begin
      @(posedge clock);
      if (reset || m_flush) begin
        fm_busy = 1'b0;
      end else if (!fm_busy && m_valid && m_ready) begin
        ea = m_signed[1] ? {{64{m_multiplicand[63]}}, m_multiplicand} : {64'd0, m_multiplicand};
        eb = m_signed[0] ? {{64{m_multiplier[63]}}, m_multiplier} : {64'd0, m_multiplier};
        p = ea * eb;
        fm_hi = p[127:64];
        fm_lo = m_mulw ? {{32{p[31]}}, p[31:0]} : p[63:0];
        fm_busy = 1'b1;
        fm_cnt = hold_long ? 30 : $urandom_range(1, 5);
      end
      #1;
      m_out_valid = 1'b0;
      if (late_req != late_done) begin
        late_done = late_req;
        m_out_valid = 1'b1;
        m_hi = 64'hDEAD_BEEF_DEAD_BEEF;
        m_lo = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (fm_busy) begin
        fm_cnt--;
        if (fm_cnt == 0) begin
          m_out_valid = 1'b1;
          m_hi = fm_hi;
          m_lo = fm_lo;
          fm_busy = 1'b0;
        end
      end
      m_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, expv);
  endtask

  // Per-cycle comparison against the current expectation.
  task automatic compare_cycle();
    checkOutput("ack_rule", 64'(ex_mul_ack), 64'(wb_valid && wb_ready && !flush));
    if (!flush) checkOutput("m_flush_idle", 64'(m_flush), 64'd0);
    if (wb_valid) begin
      checkOutput("wb_data", wb_data, exp_data);
      checkOutput("wb_rd", 64'(wb_rd), 64'(exp_rd));
    end
    if (m_valid) begin
      checkOutput("m_valid_on_bypass", 64'(exp_bypass), 64'd0);
      checkOutput("m_signed", 64'(m_signed), 64'(exp_signed));
      checkOutput("m_mulw", 64'(m_mulw), 64'(exp_mulw));
      checkOutput("m_multiplicand", m_multiplicand, exp_a);
      checkOutput("m_multiplier", m_multiplier, exp_b);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    @(negedge clock);
    compare_cycle();
  endtask

  task automatic set_expect(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    exp_data   = model_result(op, a, b);
    exp_rd     = rd;
    exp_bypass = is_bypass(op, a, b);
    exp_signed = sig_of(op);
    exp_mulw   = (op == 3'd4);
    exp_a      = a;
    exp_b      = b;
  endtask

  task automatic present(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    ex_mul_req = 1'b1;
    ex_mul_op  = op;
    ex_src1    = a;
    ex_src2    = b;
    ex_rd      = rd;
  endtask

  // One full request: accept, multiply or bypass, hold for `delay` cycles, ack.
  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input int delay, input bit use_lit, input logic [63:0] lit);
    logic prev_ov;
    int   waited;
    set_expect(op, a, b, rd);
    if (use_lit) checkOutput("model_pin", exp_data, lit);
    edge1();
    present(op, a, b, rd);
    wb_ready = 1'b0;
    cycle();
    edge1();
    cycle();
    if (exp_bypass) begin
      checkOutput("bypass_wb_n1", 64'(wb_valid), 64'd1);
    end else begin
      checkOutput("issue_m_valid_n1", 64'(m_valid), 64'd1);
      checkOutput("issue_no_wb", 64'(wb_valid), 64'd0);
    end
    prev_ov = m_out_valid;
    waited = 0;
    while (!wb_valid && waited < 100) begin
      edge1();
      cycle();
      if (wb_valid) checkOutput("wb_after_out_valid", 64'(prev_ov), 64'd1);
      prev_ov = m_out_valid;
      waited++;
    end
    checkOutput("wb_valid_reached", 64'(wb_valid), 64'd1);
    if (use_lit) checkOutput("wb_data_lit", wb_data, lit);
    for (int i = 0; i < delay; i++) begin
      edge1();
      cycle();
      checkOutput("wb_held", 64'(wb_valid), 64'd1);
    end
    edge1();
    wb_ready = 1'b1;
    cycle();
    checkOutput("ack_pulse", 64'(ex_mul_ack), 64'd1);
    edge1();
    wb_ready   = 1'b0;
    ex_mul_req = 1'b0;
    cycle();
    checkOutput("ack_single", 64'(ex_mul_ack), 64'd0);
    checkOutput("wb_dropped", 64'(wb_valid), 64'd0);
  endtask

  task automatic wait_busy();
    int waited;
    waited = 0;
    while (!fm_busy && waited < 50) begin
      edge1();
      cycle();
      waited++;
    end
    checkOutput("mult_accepted", 64'(fm_busy), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] op;
    reset = 1'b1; ex_mul_req = 1'b0; ex_mul_op = '0; ex_src1 = '0; ex_src2 = '0;
    ex_rd = '0; flush = 1'b0; wb_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_ack", 64'(ex_mul_ack), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_m_flush", 64'(m_flush), 64'd0);
    checkOutput("rst_m_signed", 64'(m_signed), 64'd0);
    checkOutput("rst_m_mulw", 64'(m_mulw), 64'd0);
    checkOutput("rst_wb_data", wb_data, 64'd0);
    checkOutput("rst_wb_rd", 64'(wb_rd), 64'd0);
    checkOutput("rst_operands", m_multiplicand | m_multiplier, 64'd0);
    edge1();
    reset = 1'b0;
    cycle();

    applyStimulus(3'd0, 64'd3, -64'sd5, 5'd1, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    applyStimulus(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 0, 1'b1, 64'd1);
    applyStimulus(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(3'd4, 64'h7FFF_FFFF, 64'd2, 5'd4, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus(3'd0, 64'h1234, 64'd0, 5'd5, 3, 1'b1, 64'd0);
    applyStimulus(3'd4, 64'hABCD_0000_0000, 64'd9, 5'd6, 0, 1'b1, 64'd0);
    applyStimulus(3'd6, 64'd5, 64'd7, 5'd7, 0, 1'b1, 64'd0);

    // Flush while waiting on the multiplier, followed by a stale out_valid.
    set_expect(3'd0, 64'd5, 64'd9, 5'd8);
    hold_long = 1'b1;
    edge1();
    present(3'd0, 64'd5, 64'd9, 5'd8);
    cycle();
    wait_busy();
    edge1();
    flush = 1'b1;
    ex_mul_req = 1'b0;
    cycle();
    checkOutput("wait_m_flush", 64'(m_flush), 64'd1);
    checkOutput("wait_flush_m_valid", 64'(m_valid), 64'd0);
    edge1();
    flush = 1'b0;
    hold_long = 1'b0;
    late_req = late_req + 1;
    cycle();
    checkOutput("m_flush_one_cycle", 64'(m_flush), 64'd0);
    for (int i = 0; i < 4; i++) begin
      edge1();
      cycle();
      checkOutput("flushed_no_wb", 64'(wb_valid), 64'd0);
      checkOutput("flushed_no_ack", 64'(ex_mul_ack), 64'd0);
    end
    applyStimulus(3'd0, 64'd7, 64'd6, 5'd9, 0, 1'b1, 64'd42);

    // Flush while the result waits for writeback, together with wb_ready.
    set_expect(3'd3, 64'd0, 64'd5, 5'd10);
    edge1();
    present(3'd3, 64'd0, 64'd5, 5'd10);
    cycle();
    edge1();
    cycle();
    checkOutput("done_flush_wb", 64'(wb_valid), 64'd1);
    edge1();
    flush = 1'b1;
    wb_ready = 1'b1;
    ex_mul_req = 1'b0;
    cycle();
    checkOutput("done_flush_no_ack", 64'(ex_mul_ack), 64'd0);
    edge1();
    flush = 1'b0;
    wb_ready = 1'b0;
    cycle();
    checkOutput("done_flush_dropped", 64'(wb_valid), 64'd0);

    // Reset in the middle of an operation: no flush pulse, no ack.
    set_expect(3'd1, 64'd9, 64'd11, 5'd11);
    hold_long = 1'b1;
    edge1();
    present(3'd1, 64'd9, 64'd11, 5'd11);
    cycle();
    wait_busy();
    edge1();
    reset = 1'b1;
    ex_mul_req = 1'b0;
    cycle();
    checkOutput("rst_mid_no_flush", 64'(m_flush), 64'd0);
    checkOutput("rst_mid_no_ack", 64'(ex_mul_ack), 64'd0);
    edge1();
    reset = 1'b0;
    hold_long = 1'b0;
    cycle();
    checkOutput("rst_mid_wb", 64'(wb_valid), 64'd0);
    checkOutput("rst_mid_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_mid_m_signed", 64'(m_signed), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      applyStimulus(op, rand_operand(), rand_operand(), 5'($urandom), $urandom_range(0, 3), 1'b0, 64'd0);
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
